// File: rtl/fetch_queue.sv
// fetch_queue: ordered instruction prefetch queue with up to DEPTH fetches in flight.
// Revision 1.0
`timescale 1ns/1ps
`default_nettype none

module fetch_queue #(
  parameter int DEPTH  = 4,
  parameter int PC_W   = 32,
  parameter int DATA_W = 32,
  parameter int EXC_W  = 5
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush_i,
  input  logic              valid_i,
  input  logic [PC_W-1:0]   pc_i,
  input  logic              exc_i,
  input  logic              exc_miss_i,
  input  logic [EXC_W-1:0]  exccode_i,
  output logic              ready_o,
  output logic              inst_req,
  output logic [PC_W-1:0]   inst_addr,
  input  logic              inst_addr_ok,
  input  logic              inst_data_ok,
  input  logic [DATA_W-1:0] inst_rdata,
  output logic              valid_o,
  output logic [PC_W-1:0]   pc_o,
  output logic [DATA_W-1:0] inst_o,
  output logic              exc_o,
  output logic              exc_miss_o,
  output logic [EXC_W-1:0]  exccode_o,
  input  logic              ready_i
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] OCC_MAX = (CNT_W+1)'(DEPTH);

  // Pointers carry one extra wrap bit so wr-fill distinguishes 0 from DEPTH live requests.
  logic [PTR_W:0]     r_wr, r_fill, r_rd;
  logic [CNT_W-1:0]   r_count, r_discard;
  logic [DEPTH-1:0]   r_done;
  logic [PC_W-1:0]    r_pc       [DEPTH];
  logic [DATA_W-1:0]  r_inst     [DEPTH];
  logic               r_exc      [DEPTH];
  logic               r_exc_miss [DEPTH];
  logic [EXC_W-1:0]   r_exccode  [DEPTH];

  logic [PTR_W-1:0]   w_wi, w_fi, w_ri;
  logic [CNT_W-1:0]   w_live, w_flush_disc;
  logic [CNT_W:0]     w_occ;
  logic               w_room, w_outst, w_alloc_n, w_alloc_e, w_alloc;
  logic               w_drop, w_fill, w_pop, w_resp;

  assign w_wi    = r_wr[PTR_W-1:0];
  assign w_fi    = r_fill[PTR_W-1:0];
  assign w_ri    = r_rd[PTR_W-1:0];
  assign w_live  = r_wr - r_fill;
  assign w_occ   = {1'b0, r_count} + {1'b0, r_discard};
  assign w_room  = (w_occ < OCC_MAX);
  assign w_outst = (w_live != '0) | (r_discard != '0);

  // Combinational outputs are gated by resetn so they drop as soon as reset asserts.
  assign inst_req  = resetn & valid_i & ~exc_i & ~flush_i & w_room;
  assign inst_addr = pc_i;
  assign w_alloc_n = inst_req & inst_addr_ok;
  assign w_alloc_e = resetn & valid_i & exc_i & ~flush_i & w_room & ~w_outst;
  assign w_alloc   = w_alloc_n | w_alloc_e;
  assign ready_o   = w_alloc;

  assign w_resp = inst_data_ok & ((r_discard != '0) | (w_live != '0));
  assign w_drop = inst_data_ok & (r_discard != '0);
  assign w_fill = inst_data_ok & (r_discard == '0) & (w_live != '0);
  assign w_flush_disc = r_discard + w_live - CNT_W'(w_resp);

  assign valid_o    = (r_count != '0) & r_done[w_ri];
  assign w_pop      = valid_o & ready_i & ~flush_i;
  assign pc_o       = r_pc[w_ri];
  assign inst_o     = r_inst[w_ri];
  assign exc_o      = r_exc[w_ri];
  assign exc_miss_o = r_exc_miss[w_ri];
  assign exccode_o  = r_exccode[w_ri];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr      <= '0;
      r_fill    <= '0;
      r_rd      <= '0;
      r_count   <= '0;
      r_discard <= '0;
      r_done    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_pc[i]       <= '0;
        r_inst[i]     <= '0;
        r_exc[i]      <= 1'b0;
        r_exc_miss[i] <= 1'b0;
        r_exccode[i]  <= '0;
      end
    end else if (flush_i) begin
      // Everything still outstanding on the bus becomes a response to be swallowed.
      r_count   <= '0;
      r_done    <= '0;
      r_rd      <= r_wr;
      r_fill    <= r_wr;
      r_discard <= w_flush_disc;
    end else begin
      if (w_alloc_n) begin
        r_pc[w_wi]       <= pc_i;
        r_exc[w_wi]      <= 1'b0;
        r_exc_miss[w_wi] <= 1'b0;
        r_exccode[w_wi]  <= '0;
        r_done[w_wi]     <= 1'b0;
      end
      if (w_alloc_e) begin
        r_pc[w_wi]       <= pc_i;
        r_inst[w_wi]     <= '0;
        r_exc[w_wi]      <= 1'b1;
        r_exc_miss[w_wi] <= exc_miss_i;
        r_exccode[w_wi]  <= exccode_i;
        r_done[w_wi]     <= 1'b1;
        r_fill           <= r_fill + 1'b1;
      end
      if (w_alloc) begin
        r_wr <= r_wr + 1'b1;
      end
      if (w_drop) begin
        r_discard <= r_discard - 1'b1;
      end
      if (w_fill) begin
        r_inst[w_fi] <= inst_rdata;
        r_done[w_fi] <= 1'b1;
        r_fill       <= r_fill + 1'b1;
      end
      if (w_pop) begin
        r_done[w_ri] <= 1'b0;
        r_rd         <= r_rd + 1'b1;
      end
      r_count <= r_count + CNT_W'(w_alloc) - CNT_W'(w_pop);
    end
  end

endmodule

`default_nettype wire
